// File: rtl/axi_mst_arbiter.sv
// Round-robin N-to-1 merge of simple upstream master ports onto one AXI4 master bus.
// One single-beat transaction is outstanding at a time; reads and writes share the FSM.
module axi_mst_arbiter #(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // upstream read
    input  logic [N_MST-1:0]          mst_ar_valid_i,
    output logic [N_MST-1:0]          mst_ar_ready_o,
    input  logic [N_MST*ADDR_W-1:0]   mst_ar_addr_i,
    input  logic [N_MST*3-1:0]        mst_ar_size_i,
    output logic [N_MST-1:0]          mst_r_valid_o,
    input  logic [N_MST-1:0]          mst_r_ready_i,
    output logic [DATA_W-1:0]         mst_r_data_o,
    output logic [1:0]                mst_r_resp_o,
    // upstream write
    input  logic [N_MST-1:0]          mst_aw_valid_i,
    output logic [N_MST-1:0]          mst_aw_ready_o,
    input  logic [N_MST*ADDR_W-1:0]   mst_aw_addr_i,
    input  logic [N_MST*3-1:0]        mst_aw_size_i,
    input  logic [N_MST-1:0]          mst_w_valid_i,
    output logic [N_MST-1:0]          mst_w_ready_o,
    input  logic [N_MST*DATA_W-1:0]   mst_w_data_i,
    input  logic [N_MST*DATA_W/8-1:0] mst_w_strb_i,
    output logic [N_MST-1:0]          mst_b_valid_o,
    input  logic [N_MST-1:0]          mst_b_ready_i,
    output logic [1:0]                mst_b_resp_o,
    // downstream AXI4 master
    input  logic                      io_master_awready,
    output logic                      io_master_awvalid,
    output logic [ADDR_W-1:0]         io_master_awaddr,
    output logic [ID_W-1:0]           io_master_awid,
    output logic [7:0]                io_master_awlen,
    output logic [2:0]                io_master_awsize,
    output logic [1:0]                io_master_awburst,
    input  logic                      io_master_wready,
    output logic                      io_master_wvalid,
    output logic [DATA_W-1:0]         io_master_wdata,
    output logic [DATA_W/8-1:0]       io_master_wstrb,
    output logic                      io_master_wlast,
    output logic                      io_master_bready,
    input  logic                      io_master_bvalid,
    input  logic [1:0]                io_master_bresp,
    input  logic                      io_master_arready,
    output logic                      io_master_arvalid,
    output logic [ADDR_W-1:0]         io_master_araddr,
    output logic [ID_W-1:0]           io_master_arid,
    output logic [7:0]                io_master_arlen,
    output logic [2:0]                io_master_arsize,
    output logic [1:0]                io_master_arburst,
    output logic                      io_master_rready,
    input  logic                      io_master_rvalid,
    input  logic [1:0]                io_master_rresp,
    input  logic [DATA_W-1:0]         io_master_rdata,
    output logic [2:0]                dbg_state_o
);
    localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int SW = DATA_W / 8;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] AR   = 3'd1;
    localparam logic [2:0] R    = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] B    = 3'd4;

    // Handshakes: every channel transfers on a cycle where valid and ready are both high;
    // valids never depend on ready, and downstream valids are held until their handshake.

    logic [ADDR_W-1:0] ar_addr_a [N_MST];
    logic [ADDR_W-1:0] aw_addr_a [N_MST];
    logic [2:0]        ar_size_a [N_MST];
    logic [2:0]        aw_size_a [N_MST];
    logic [DATA_W-1:0] w_data_a  [N_MST];
    logic [SW-1:0]     w_strb_a  [N_MST];

    for (genvar k = 0; k < N_MST; k++) begin : g_unpack
        assign ar_addr_a[k] = mst_ar_addr_i[k*ADDR_W +: ADDR_W];
        assign aw_addr_a[k] = mst_aw_addr_i[k*ADDR_W +: ADDR_W];
        assign ar_size_a[k] = mst_ar_size_i[k*3 +: 3];
        assign aw_size_a[k] = mst_aw_size_i[k*3 +: 3];
        assign w_data_a[k]  = mst_w_data_i[k*DATA_W +: DATA_W];
        assign w_strb_a[k]  = mst_w_strb_i[k*SW +: SW];
    end

    logic [2:0]        state;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SW-1:0]     wstrb_q;
    logic              arvalid_q;
    logic              awvalid_q;
    logic              wvalid_q;

    logic [N_MST-1:0]  wr_req;
    logic [N_MST-1:0]  req;
    logic [GW-1:0]     cand;
    logic [GW-1:0]     winner;
    logic              found;
    logic              accept;
    logic              win_wr;
    logic [N_MST-1:0]  win_oh;
    logic [N_MST-1:0]  grant_oh;
    logic              aw_done;
    logic              w_done;

    assign wr_req = mst_aw_valid_i & mst_w_valid_i;
    assign req    = mst_ar_valid_i | wr_req;

    // Search begins one past the previous winner so every requester is served in turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= N_MST; i++) begin
            cand = GW'((int'(last_grant) + i) % N_MST);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Gating with rst_i keeps upstream readys low while reset is held.
    assign accept   = rst_i && (state == IDLE) && found;
    assign win_wr   = wr_req[winner];
    assign win_oh   = N_MST'(1) << winner;
    assign grant_oh = N_MST'(1) << grant_q;

    assign mst_ar_ready_o = (accept && !win_wr) ? win_oh : '0;
    assign mst_aw_ready_o = (accept && win_wr) ? win_oh : '0;
    assign mst_w_ready_o  = (accept && win_wr) ? win_oh : '0;

    assign aw_done = !awvalid_q || io_master_awready;
    assign w_done  = !wvalid_q || io_master_wready;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            last_grant <= GW'(N_MST - 1);
            grant_q    <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_q    <= winner;
                        last_grant <= winner;
                        if (win_wr) begin
                            addr_q    <= aw_addr_a[winner];
                            size_q    <= aw_size_a[winner];
                            wdata_q   <= w_data_a[winner];
                            wstrb_q   <= w_strb_a[winner];
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR;
                        end else begin
                            addr_q    <= ar_addr_a[winner];
                            size_q    <= ar_size_a[winner];
                            arvalid_q <= 1'b1;
                            state     <= AR;
                        end
                    end
                end
                AR: begin
                    if (io_master_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= R;
                    end
                end
                R: begin
                    if (io_master_rvalid && io_master_rready) state <= IDLE;
                end
                WR: begin
                    if (io_master_awready) awvalid_q <= 1'b0;
                    if (io_master_wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) state <= B;
                end
                B: begin
                    if (io_master_bvalid && io_master_bready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io_master_arvalid = arvalid_q;
    assign io_master_araddr  = (state == AR) ? addr_q : '0;
    assign io_master_arid    = (state == AR) ? ID_W'(grant_q) : '0;
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = (state == AR) ? size_q : 3'd0;
    assign io_master_arburst = (state == AR) ? 2'b01 : 2'b00;

    assign io_master_awvalid = awvalid_q;
    assign io_master_awaddr  = (state == WR) ? addr_q : '0;
    assign io_master_awid    = (state == WR) ? ID_W'(grant_q) : '0;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = (state == WR) ? size_q : 3'd0;
    assign io_master_awburst = (state == WR) ? 2'b01 : 2'b00;

    assign io_master_wvalid  = wvalid_q;
    assign io_master_wdata   = (state == WR) ? wdata_q : '0;
    assign io_master_wstrb   = (state == WR) ? wstrb_q : '0;
    assign io_master_wlast   = wvalid_q;

    // Response channels are steered combinationally to and from the granted master only.
    assign io_master_rready = (state == R) && mst_r_ready_i[grant_q];
    assign mst_r_valid_o    = ((state == R) && io_master_rvalid) ? grant_oh : '0;
    assign mst_r_data_o     = (state == R) ? io_master_rdata : '0;
    assign mst_r_resp_o     = (state == R) ? io_master_rresp : 2'b00;

    assign io_master_bready = (state == B) && mst_b_ready_i[grant_q];
    assign mst_b_valid_o    = ((state == B) && io_master_bvalid) ? grant_oh : '0;
    assign mst_b_resp_o     = (state == B) ? io_master_bresp : 2'b00;

    assign dbg_state_o = state;
endmodule

// File: tb/tb_axi_mst_arbiter.sv
// Bench for axi_mst_arbiter: a 2-master instance for most scenarios, a 4-master one for ID/gating.
module tb_axi_mst_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [35:0] exp_q[$];

    // ---------------- 2-master instance ----------------
    logic [1:0]  a_ar_valid, a_ar_ready, a_r_valid, a_r_ready, a_r_resp;
    logic [63:0] a_ar_addr, a_aw_addr, a_w_data;
    logic [5:0]  a_ar_size, a_aw_size;
    logic [31:0] a_r_data;
    logic [1:0]  a_aw_valid, a_aw_ready, a_w_valid, a_w_ready, a_b_valid, a_b_ready, a_b_resp;
    logic [7:0]  a_w_strb;
    logic a_awready, a_awvalid, a_wready, a_wvalid, a_wlast, a_bready, a_bvalid;
    logic a_arready, a_arvalid, a_rready, a_rvalid;
    logic [31:0] a_awaddr, a_wdata, a_araddr, a_rdata;
    logic [3:0]  a_awid, a_arid, a_wstrb;
    logic [7:0]  a_awlen, a_arlen;
    logic [2:0]  a_awsize, a_arsize, a_state;
    logic [1:0]  a_awburst, a_arburst, a_bresp, a_rresp;

    axi_mst_arbiter #(.N_MST(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut_a (
        .clk_i(clk), .rst_i(rst_n),
        .mst_ar_valid_i(a_ar_valid), .mst_ar_ready_o(a_ar_ready), .mst_ar_addr_i(a_ar_addr),
        .mst_ar_size_i(a_ar_size), .mst_r_valid_o(a_r_valid), .mst_r_ready_i(a_r_ready),
        .mst_r_data_o(a_r_data), .mst_r_resp_o(a_r_resp),
        .mst_aw_valid_i(a_aw_valid), .mst_aw_ready_o(a_aw_ready), .mst_aw_addr_i(a_aw_addr),
        .mst_aw_size_i(a_aw_size), .mst_w_valid_i(a_w_valid), .mst_w_ready_o(a_w_ready),
        .mst_w_data_i(a_w_data), .mst_w_strb_i(a_w_strb),
        .mst_b_valid_o(a_b_valid), .mst_b_ready_i(a_b_ready), .mst_b_resp_o(a_b_resp),
        .io_master_awready(a_awready), .io_master_awvalid(a_awvalid), .io_master_awaddr(a_awaddr),
        .io_master_awid(a_awid), .io_master_awlen(a_awlen), .io_master_awsize(a_awsize),
        .io_master_awburst(a_awburst), .io_master_wready(a_wready), .io_master_wvalid(a_wvalid),
        .io_master_wdata(a_wdata), .io_master_wstrb(a_wstrb), .io_master_wlast(a_wlast),
        .io_master_bready(a_bready), .io_master_bvalid(a_bvalid), .io_master_bresp(a_bresp),
        .io_master_arready(a_arready), .io_master_arvalid(a_arvalid), .io_master_araddr(a_araddr),
        .io_master_arid(a_arid), .io_master_arlen(a_arlen), .io_master_arsize(a_arsize),
        .io_master_arburst(a_arburst), .io_master_rready(a_rready), .io_master_rvalid(a_rvalid),
        .io_master_rresp(a_rresp), .io_master_rdata(a_rdata), .dbg_state_o(a_state)
    );

    // ---------------- 4-master instance ----------------
    logic [3:0]   b_ar_valid, b_ar_ready, b_r_valid, b_r_ready;
    logic [3:0]   b_aw_valid, b_aw_ready, b_w_valid, b_w_ready, b_b_valid, b_b_ready;
    logic [127:0] b_ar_addr, b_aw_addr, b_w_data;
    logic [11:0]  b_ar_size, b_aw_size;
    logic [15:0]  b_w_strb;
    logic [31:0]  b_r_data;
    logic [1:0]   b_r_resp, b_b_resp;
    logic b_awready, b_awvalid, b_wready, b_wvalid, b_wlast, b_bready, b_bvalid;
    logic b_arready, b_arvalid, b_rready, b_rvalid;
    logic [31:0] b_awaddr, b_wdata, b_araddr, b_rdata;
    logic [3:0]  b_awid, b_arid, b_wstrb;
    logic [7:0]  b_awlen, b_arlen;
    logic [2:0]  b_awsize, b_arsize, b_state;
    logic [1:0]  b_awburst, b_arburst, b_bresp, b_rresp;

    axi_mst_arbiter #(.N_MST(4), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst_n),
        .mst_ar_valid_i(b_ar_valid), .mst_ar_ready_o(b_ar_ready), .mst_ar_addr_i(b_ar_addr),
        .mst_ar_size_i(b_ar_size), .mst_r_valid_o(b_r_valid), .mst_r_ready_i(b_r_ready),
        .mst_r_data_o(b_r_data), .mst_r_resp_o(b_r_resp),
        .mst_aw_valid_i(b_aw_valid), .mst_aw_ready_o(b_aw_ready), .mst_aw_addr_i(b_aw_addr),
        .mst_aw_size_i(b_aw_size), .mst_w_valid_i(b_w_valid), .mst_w_ready_o(b_w_ready),
        .mst_w_data_i(b_w_data), .mst_w_strb_i(b_w_strb),
        .mst_b_valid_o(b_b_valid), .mst_b_ready_i(b_b_ready), .mst_b_resp_o(b_b_resp),
        .io_master_awready(b_awready), .io_master_awvalid(b_awvalid), .io_master_awaddr(b_awaddr),
        .io_master_awid(b_awid), .io_master_awlen(b_awlen), .io_master_awsize(b_awsize),
        .io_master_awburst(b_awburst), .io_master_wready(b_wready), .io_master_wvalid(b_wvalid),
        .io_master_wdata(b_wdata), .io_master_wstrb(b_wstrb), .io_master_wlast(b_wlast),
        .io_master_bready(b_bready), .io_master_bvalid(b_bvalid), .io_master_bresp(b_bresp),
        .io_master_arready(b_arready), .io_master_arvalid(b_arvalid), .io_master_araddr(b_araddr),
        .io_master_arid(b_arid), .io_master_arlen(b_arlen), .io_master_arsize(b_arsize),
        .io_master_arburst(b_arburst), .io_master_rready(b_rready), .io_master_rvalid(b_rvalid),
        .io_master_rresp(b_rresp), .io_master_rdata(b_rdata), .dbg_state_o(b_state)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sb_pop(input string name, input logic [35:0] act);
        logic [35:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: got 0x%0h expected nothing (queue empty)", name, act);
        end else begin
            e = exp_q.pop_front();
            chk(name, 64'(act), 64'(e));
        end
    endtask

    function automatic logic [63:0] oh(input int g);
        return 64'(1) << g;
    endfunction

    function automatic logic [31:0] rd_addr(input int g);
        return (g == 1) ? 32'h8000_0010 : 32'h0000_1000;
    endfunction
    function automatic logic [2:0] rd_size(input int g);
        return (g == 1) ? 3'd2 : 3'd1;
    endfunction
    function automatic logic [31:0] wr_addr(input int g);
        return (g == 1) ? 32'h9000_0020 : 32'h0000_2000;
    endfunction
    function automatic logic [31:0] wr_data(input int g);
        return (g == 1) ? 32'h1234_5678 : 32'hCAFE_F00D;
    endfunction
    function automatic logic [3:0] wr_strb(input int g);
        return (g == 1) ? 4'b0011 : 4'b1111;
    endfunction

    // ---------------- driver tasks (entered just after a falling edge) ----------------
    task automatic a_read(input int g, input logic [1:0] req, input logic [31:0] rd);
        a_ar_valid = req;
        #1;
        chk("rd_accept_ready", 64'(a_ar_ready), oh(g));
        exp_q.push_back({4'(g), rd_addr(g)});
        @(negedge clk);
        a_arready = 1'b1;
        #1;
        chk("arvalid_c1", 64'(a_arvalid), 64'(1));
        chk("ar_ready_busy", 64'(a_ar_ready), 64'(0));
        chk("ar_len_burst_size", 64'({a_arlen, a_arburst, a_arsize}), 64'({8'd0, 2'b01, rd_size(g)}));
        sb_pop("ar_id_addr", {a_arid, a_araddr});
        @(negedge clk);
        a_arready = 1'b0;
        a_rvalid = 1'b1;
        a_rdata = rd;
        a_r_ready = 2'(oh(g));
        #1;
        chk("r_valid", 64'(a_r_valid), oh(g));
        chk("r_data", 64'(a_r_data), 64'(rd));
        chk("rready", 64'(a_rready), 64'(1));
        @(negedge clk);
        a_rvalid = 1'b0;
        a_r_ready = 2'b00;
        #1;
        chk("rd_back_idle", 64'(a_state), 64'(0));
    endtask

    task automatic a_write(input int g, input int aw_lat, input int w_lat, input logic [1:0] resp);
        int n;
        n = (aw_lat > w_lat) ? aw_lat : w_lat;
        a_aw_valid = 2'(oh(g));
        a_w_valid = 2'(oh(g));
        #1;
        chk("aw_accept_ready", 64'(a_aw_ready), oh(g));
        chk("w_accept_ready", 64'(a_w_ready), oh(g));
        chk("ar_ready_on_wr", 64'(a_ar_ready), 64'(0));
        exp_q.push_back({4'(g), wr_addr(g)});
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            a_aw_valid = 2'b00;
            a_w_valid = 2'b00;
            a_awready = (c == aw_lat);
            a_wready = (c == w_lat);
            #1;
            chk("awvalid_hold", 64'(a_awvalid), 64'(c <= aw_lat));
            chk("wvalid_hold", 64'(a_wvalid), 64'(c <= w_lat));
            if (c == aw_lat) begin
                sb_pop("aw_id_addr", {a_awid, a_awaddr});
                chk("aw_len_burst", 64'({a_awlen, a_awburst}), 64'({8'd0, 2'b01}));
            end
            if (c == w_lat)
                chk("w_beat", 64'({a_wdata, a_wstrb, a_wlast}), 64'({wr_data(g), wr_strb(g), 1'b1}));
        end
        @(negedge clk);
        a_awready = 1'b0;
        a_wready = 1'b0;
        a_bvalid = 1'b1;
        a_bresp = resp;
        a_b_ready = 2'(oh(g));
        #1;
        chk("b_valid", 64'(a_b_valid), oh(g));
        chk("b_resp", 64'(a_b_resp), 64'(resp));
        chk("bready", 64'(a_bready), 64'(1));
        @(negedge clk);
        a_bvalid = 1'b0;
        a_b_ready = 2'b00;
        #1;
        chk("wr_back_idle", 64'(a_state), 64'(0));
    endtask

    typedef struct {
        logic [1:0] ar_v;
        logic [1:0] aw_v;
        logic [1:0] w_v;
        logic [1:0] e_ar;
        logic [1:0] e_aw;
        logic [1:0] e_w;
    } vec_t;
    vec_t tbl[11];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        a_ar_valid = '0; a_aw_valid = '0; a_w_valid = '0; a_r_ready = '0; a_b_ready = '0;
        a_ar_addr = {rd_addr(1), rd_addr(0)};
        a_ar_size = {rd_size(1), rd_size(0)};
        a_aw_addr = {wr_addr(1), wr_addr(0)};
        a_aw_size = {3'd2, 3'd2};
        a_w_data = {wr_data(1), wr_data(0)};
        a_w_strb = {wr_strb(1), wr_strb(0)};
        a_awready = 0; a_wready = 0; a_bvalid = 0; a_bresp = 0;
        a_arready = 0; a_rvalid = 0; a_rresp = 0; a_rdata = 0;
        b_ar_valid = '0; b_aw_valid = '0; b_w_valid = '0; b_r_ready = '0; b_b_ready = '0;
        b_ar_addr = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000, 32'h0000_0000};
        b_ar_size = {3'd2, 3'd2, 3'd2, 3'd2};
        b_aw_addr = '0; b_aw_size = '0; b_w_data = '0; b_w_strb = '0;
        b_awready = 0; b_wready = 0; b_bvalid = 0; b_bresp = 0;
        b_arready = 0; b_rvalid = 0; b_rresp = 0; b_rdata = 0;

        // ar, aw, w requests -> expected ar/aw/w readys with last_grant at its reset value
        tbl[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        tbl[2]  = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        tbl[3]  = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        tbl[4]  = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
        tbl[5]  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
        tbl[6]  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[7]  = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
        tbl[9]  = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
        tbl[10] = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b10, 2'b10};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_a", 64'({a_state, a_arvalid, a_awvalid, a_wvalid, a_rready, a_bready}), 64'(0));
        chk("reset_b", 64'({b_state, b_arvalid, b_awvalid, b_wvalid, b_rready, b_bready}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            a_ar_valid = tbl[i].ar_v;
            a_aw_valid = tbl[i].aw_v;
            a_w_valid = tbl[i].w_v;
            #1;
            chk($sformatf("tbl_ready_%0d", i), 64'({a_ar_ready, a_aw_ready, a_w_ready}),
                64'({tbl[i].e_ar, tbl[i].e_aw, tbl[i].e_w}));
            a_ar_valid = '0; a_aw_valid = '0; a_w_valid = '0;
        end
        @(negedge clk);
        #1;
        chk("idle_no_req", 64'({a_state, a_arvalid, a_awvalid, a_r_valid, a_b_valid}), 64'(0));

        // single read from master 1, zero-wait slave; next acceptance possible in c3
        a_read(1, 2'b10, 32'hDEAD_BEEF);
        a_ar_valid = 2'b00;

        // both masters reading continuously: strict alternation starting at master 0
        for (int i = 0; i < 6; i++) a_read(i % 2, 2'b11, 32'hA000_0000 + 32'(i));
        a_ar_valid = 2'b00;

        // write from master 1: w handshakes in c1, aw stalls until c4, SLVERR returned
        @(negedge clk);
        a_write(1, 4, 1, 2'b10);
        // write from master 0 with the opposite order: aw first, w later
        a_write(0, 1, 3, 2'b00);

        // master 0 presents read and write together: write first, read on the next IDLE
        a_ar_valid = 2'b01;
        a_write(0, 1, 1, 2'b01);
        a_read(0, 2'b01, 32'h0BAD_F00D);
        a_ar_valid = 2'b00;

        // asynchronous reset while a read response is pending
        @(negedge clk);
        a_ar_valid = 2'b01;
        #1;
        chk("pre_rst_accept", 64'(a_ar_ready), 64'(2'b01));
        @(negedge clk);
        a_arready = 1'b1;
        @(negedge clk);
        a_arready = 1'b0;
        a_rvalid = 1'b1;
        a_rdata = 32'h5555_AAAA;
        a_r_ready = 2'b00;
        #1;
        chk("pre_rst_r_valid", 64'(a_r_valid), 64'(2'b01));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 64'({a_state, a_arvalid, a_awvalid, a_wvalid, a_rready, a_bready,
            a_r_valid, a_b_valid, a_ar_ready, a_aw_ready, a_w_ready}), 64'(0));
        chk("async_rst_rdata", 64'(a_r_data), 64'(0));
        @(negedge clk);
        a_rvalid = 1'b0;
        a_ar_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        a_read(0, 2'b11, 32'h1111_2222);
        a_read(1, 2'b11, 32'h3333_4444);
        a_ar_valid = 2'b00;

        // 4-master instance: masters 2 and 3 read; IDs and rready gating
        @(negedge clk);
        b_ar_valid = 4'b1100;
        #1;
        chk("b_ready_m2", 64'(b_ar_ready), 64'(4'b0100));
        @(negedge clk);
        b_arready = 1'b1;
        #1;
        chk("b_arid_m2", 64'({b_arvalid, b_arid, b_araddr}), 64'({1'b1, 4'd2, 32'h2222_0000}));
        @(negedge clk);
        b_arready = 1'b0;
        b_rvalid = 1'b1;
        b_r_ready = 4'b0100;
        #1;
        chk("b_r_valid_m2", 64'({b_r_valid, b_rready}), 64'({4'b0100, 1'b1}));
        @(negedge clk);
        b_rvalid = 1'b0;
        b_r_ready = 4'b0000;
        #1;
        chk("b_ready_m3", 64'({b_state, b_ar_ready}), 64'({3'd0, 4'b1000}));
        @(negedge clk);
        b_ar_valid = 4'b0000;
        b_arready = 1'b1;
        #1;
        chk("b_arid_m3", 64'({b_arvalid, b_arid, b_araddr}), 64'({1'b1, 4'd3, 32'h3333_0000}));
        @(negedge clk);
        b_arready = 1'b0;
        b_rvalid = 1'b1;
        b_r_ready = 4'b0111;
        #1;
        chk("b_rready_gated", 64'({b_r_valid, b_rready}), 64'({4'b1000, 1'b0}));
        @(negedge clk);
        b_r_ready = 4'b1000;
        #1;
        chk("b_rready_pass", 64'({b_state, b_rready}), 64'({3'd2, 1'b1}));
        @(negedge clk);
        b_rvalid = 1'b0;
        b_r_ready = 4'b0000;
        #1;
        chk("b_back_idle", 64'(b_state), 64'(0));

        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
